// File: rtl/fpu_addsub_seq.sv
// Sequential single-precision add/subtract.
// Multi-cycle datapath: unpack, serial align, add, serial normalise.
// Rounding is truncation and denormal inputs are flushed to zero.
//
// state  | meaning
// IDLE   | ready, waiting for start
// UNPACK | decode operands, resolve specials, order big/small
// ALIGN  | shift small mantissa right one bit per cycle
// ADD    | add or subtract aligned mantissas
// NORM   | one normalisation step per cycle
// DONE   | publish result and flags, pulse done
module fpu_addsub_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        op,
    output logic        ready,
    output logic        done,
    output logic [31:0] result,
    output logic        nan,
    output logic        zero,
    output logic        ovf
);

    typedef enum logic [2:0] {
        IDLE, UNPACK, ALIGN, ADD, NORM, DONE
    } state_t;

    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    state_t      state_q, state_d;
    logic [31:0] a_q, a_d, b_q, b_d;
    logic        op_q, op_d;
    logic        sign_q, sign_d;
    logic        eff_sub_q, eff_sub_d;
    logic [7:0]  exp_q, exp_d;
    logic [24:0] mant_q, mant_d;
    logic [23:0] msml_q, msml_d;
    logic [4:0]  d_q, d_d;
    logic [31:0] pend_res_q, pend_res_d;
    logic        pend_nan_q, pend_nan_d;
    logic        pend_zero_q, pend_zero_d;
    logic        pend_ovf_q, pend_ovf_d;
    logic        done_q, done_d;
    logic [31:0] result_q, result_d;
    logic        nan_q, nan_d, zero_q, zero_d, ovf_q, ovf_d;

    // Operand decode of the registered inputs, used only in UNPACK.
    logic [7:0]  ea, eb, ebig, esml, ediff;
    logic [22:0] fa, fb;
    logic        sa, sb, za, zb, nan_a, nan_b, inf_a, inf_b, a_big;

    assign ea    = a_q[30:23];
    assign eb    = b_q[30:23];
    assign za    = (ea == 8'd0);
    assign zb    = (eb == 8'd0);
    assign fa    = za ? 23'd0 : a_q[22:0];
    assign fb    = zb ? 23'd0 : b_q[22:0];
    assign sa    = a_q[31];
    assign sb    = b_q[31] ^ op_q;
    assign nan_a = (ea == 8'hFF) && (a_q[22:0] != 23'd0);
    assign nan_b = (eb == 8'hFF) && (b_q[22:0] != 23'd0);
    assign inf_a = (ea == 8'hFF) && (a_q[22:0] == 23'd0);
    assign inf_b = (eb == 8'hFF) && (b_q[22:0] == 23'd0);
    assign a_big = ({ea, fa} >= {eb, fb});
    assign ebig  = a_big ? ea : eb;
    assign esml  = a_big ? eb : ea;
    assign ediff = ebig - esml;

    // Next-state and datapath updates for every state.
    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        op_d        = op_q;
        sign_d      = sign_q;
        eff_sub_d   = eff_sub_q;
        exp_d       = exp_q;
        mant_d      = mant_q;
        msml_d      = msml_q;
        d_d         = d_q;
        pend_res_d  = pend_res_q;
        pend_nan_d  = pend_nan_q;
        pend_zero_d = pend_zero_q;
        pend_ovf_d  = pend_ovf_q;
        done_d      = 1'b0;
        result_d    = result_q;
        nan_d       = nan_q;
        zero_d      = zero_q;
        ovf_d       = ovf_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    op_d    = op;
                    state_d = UNPACK;
                end
            end
            UNPACK: begin
                pend_nan_d  = 1'b0;
                pend_zero_d = 1'b0;
                pend_ovf_d  = 1'b0;
                state_d     = DONE;
                if (nan_a || nan_b || (inf_a && inf_b && (sa != sb))) begin
                    pend_res_d = QNAN;
                    pend_nan_d = 1'b1;
                end else if (inf_a) begin
                    pend_res_d = {sa, 8'hFF, 23'd0};
                end else if (inf_b) begin
                    pend_res_d = {sb, 8'hFF, 23'd0};
                end else if (za && zb) begin
                    pend_res_d  = {sa & sb, 31'd0};
                    pend_zero_d = 1'b1;
                end else begin
                    sign_d    = a_big ? sa : sb;
                    eff_sub_d = sa ^ sb;
                    exp_d     = ebig;
                    mant_d    = a_big ? {1'b0, ~za, fa} : {1'b0, ~zb, fb};
                    msml_d    = a_big ? {~zb, fb} : {~za, fa};
                    d_d       = (ediff > 8'd25) ? 5'd25 : ediff[4:0];
                    state_d   = (ediff == 8'd0) ? ADD : ALIGN;
                end
            end
            ALIGN: begin
                msml_d = msml_q >> 1;
                d_d    = d_q - 5'd1;
                if (d_q == 5'd1) state_d = ADD;
            end
            ADD: begin
                if (eff_sub_q) begin
                    mant_d = mant_q - {1'b0, msml_q};
                    if (mant_q == {1'b0, msml_q}) sign_d = 1'b0;
                end else begin
                    mant_d = mant_q + {1'b0, msml_q};
                end
                state_d = NORM;
            end
            NORM: begin
                state_d = DONE;
                if (mant_q[24]) begin
                    if (exp_q == 8'd254) begin
                        pend_res_d = {sign_q, 8'hFF, 23'd0};
                        pend_ovf_d = 1'b1;
                    end else begin
                        pend_res_d = {sign_q, exp_q + 8'd1, mant_q[23:1]};
                    end
                end else if (mant_q == 25'd0) begin
                    pend_res_d  = {sign_q, 31'd0};
                    pend_zero_d = 1'b1;
                end else if (!mant_q[23]) begin
                    if (exp_q == 8'd1) begin
                        pend_res_d  = {sign_q, 31'd0};
                        pend_zero_d = 1'b1;
                    end else begin
                        mant_d  = mant_q << 1;
                        exp_d   = exp_q - 8'd1;
                        state_d = NORM;
                    end
                end else begin
                    pend_res_d = {sign_q, exp_q, mant_q[22:0]};
                end
            end
            DONE: begin
                result_d = pend_res_q;
                nan_d    = pend_nan_q;
                zero_d   = pend_zero_q;
                ovf_d    = pend_ovf_q;
                done_d   = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= 1'b0;
            sign_q      <= 1'b0;
            eff_sub_q   <= 1'b0;
            exp_q       <= '0;
            mant_q      <= '0;
            msml_q      <= '0;
            d_q         <= '0;
            pend_res_q  <= '0;
            pend_nan_q  <= 1'b0;
            pend_zero_q <= 1'b0;
            pend_ovf_q  <= 1'b0;
            done_q      <= 1'b0;
            result_q    <= '0;
            nan_q       <= 1'b0;
            zero_q      <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            op_q        <= op_d;
            sign_q      <= sign_d;
            eff_sub_q   <= eff_sub_d;
            exp_q       <= exp_d;
            mant_q      <= mant_d;
            msml_q      <= msml_d;
            d_q         <= d_d;
            pend_res_q  <= pend_res_d;
            pend_nan_q  <= pend_nan_d;
            pend_zero_q <= pend_zero_d;
            pend_ovf_q  <= pend_ovf_d;
            done_q      <= done_d;
            result_q    <= result_d;
            nan_q       <= nan_d;
            zero_q      <= zero_d;
            ovf_q       <= ovf_d;
        end
    end

    assign ready  = (state_q == IDLE);
    assign done   = done_q;
    assign result = result_q;
    assign nan    = nan_q;
    assign zero   = zero_q;
    assign ovf    = ovf_q;

endmodule

// File: tb/tb_fpu_addsub_seq.sv
// Bench for fpu_addsub_seq: directed scenarios plus randomized operands
// compared against an arithmetic reference model.
module tb_fpu_addsub_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] a, b;
    logic        op;
    logic        ready, done;
    logic [31:0] result;
    logic        nan, zero, ovf;

    int checks = 0;
    int errors = 0;

    fpu_addsub_seq dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .op(op),
        .ready(ready), .done(done), .result(result),
        .nan(nan), .zero(zero), .ovf(ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Reference: value-level add/subtract with truncation, plus expected latency.
    task automatic model(input logic [31:0] ta, input logic [31:0] tb, input logic top,
                         output logic [31:0] r, output logic n, output logic z,
                         output logic o, output int lat);
        int ea, eb, ma, mb, sa, sb, eB, eS, mB, mS, sB, d, m, e, lz, sg;
        bit na, nb, ia, ib;
        longint maga, magb;
        ea = int'(ta[30:23]);
        eb = int'(tb[30:23]);
        ma = (ea == 0) ? 0 : int'(ta[22:0]) + (1 << 23);
        mb = (eb == 0) ? 0 : int'(tb[22:0]) + (1 << 23);
        sa = int'(ta[31]);
        sb = int'(tb[31] ^ top);
        na = (ea == 255) && (ta[22:0] != 0);
        nb = (eb == 255) && (tb[22:0] != 0);
        ia = (ea == 255) && (ta[22:0] == 0);
        ib = (eb == 255) && (tb[22:0] == 0);
        n = 0; z = 0; o = 0; lat = 2; r = 0;
        if (na || nb || (ia && ib && sa != sb)) begin
            r = 32'h7FC0_0000; n = 1;
        end else if (ia) begin
            r = {sa[0], 8'hFF, 23'd0};
        end else if (ib) begin
            r = {sb[0], 8'hFF, 23'd0};
        end else if (ea == 0 && eb == 0) begin
            r = {sa[0] & sb[0], 31'd0}; z = 1;
        end else begin
            maga = longint'(ea) * (64'd1 << 24) + longint'(ma);
            magb = longint'(eb) * (64'd1 << 24) + longint'(mb);
            if (maga >= magb) begin
                eB = ea; mB = ma; sB = sa; eS = eb; mS = mb;
            end else begin
                eB = eb; mB = mb; sB = sb; eS = ea; mS = ma;
            end
            d = eB - eS;
            if (d > 25) d = 25;
            mS = mS >> d;
            m = (sa == sb) ? mB + mS : mB - mS;
            sg = (m == 0) ? 0 : sB;
            e = eB;
            lat = 4 + d;
            if (m == 0) begin
                r = 32'd0; z = 1;
            end else if (m >= (1 << 24)) begin
                m = m >> 1;
                e = e + 1;
                if (e >= 255) begin
                    r = {sg[0], 8'hFF, 23'd0}; o = 1;
                end else begin
                    r = {sg[0], e[7:0], m[22:0]};
                end
            end else begin
                lz = 0;
                while (((m << lz) & (1 << 23)) == 0) lz++;
                if (lz >= e) begin
                    r = {sg[0], 31'd0}; z = 1;
                    lat = lat + e - 1;
                end else begin
                    m = m << lz;
                    e = e - lz;
                    r = {sg[0], e[7:0], m[22:0]};
                    lat = lat + lz;
                end
            end
        end
    endtask

    // One operation: optional start held while busy, optional reset release with start.
    task automatic run_op(input logic [31:0] ta, input logic [31:0] tb, input logic top,
                          input bit hold, input bit rel_rst);
        logic [31:0] er;
        logic en, ez, eo;
        int elat, cyc;
        bit got;
        model(ta, tb, top, er, en, ez, eo, elat);
        @(negedge clk);
        a = ta; b = tb; op = top; start = 1'b1;
        if (rel_rst) rst = 1'b0;
        @(posedge clk);
        #1;
        if (hold) begin
            a = $urandom; b = $urandom; op = ~top;
        end else begin
            start = 1'b0;
        end
        cyc = 0;
        got = 0;
        while (!got && cyc < 80) begin
            @(posedge clk);
            #1;
            cyc++;
            if (done) got = 1;
        end
        start = 1'b0;
        chk($sformatf("latency %h%s%h", ta, top ? "-" : "+", tb), cyc, elat);
        chk("result", result, er);
        chk("nan", {31'd0, nan}, {31'd0, en});
        chk("zero", {31'd0, zero}, {31'd0, ez});
        chk("ovf", {31'd0, ovf}, {31'd0, eo});
        @(posedge clk);
        #1;
        chk("done_one_cycle", {31'd0, done}, 32'd0);
        chk("ready_after", {31'd0, ready}, 32'd1);
        chk("result_held", result, er);
    endtask

    initial begin
        logic [31:0] ra, rb;
        logic [7:0]  etmp;
        int sel;

        rst = 1'b1; start = 1'b0; a = '0; b = '0; op = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", {31'd0, ready}, 32'd1);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_flags", {29'd0, nan, zero, ovf}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        run_op(32'h3F80_0000, 32'h3F80_0000, 1'b0, 0, 0);
        run_op(32'h3FC0_0000, 32'h3F80_0000, 1'b1, 0, 0);
        run_op(32'h3F80_0000, 32'h3E00_0000, 1'b0, 0, 0);
        run_op(32'h3F80_0000, 32'h3F80_0000, 1'b1, 0, 0);
        run_op(32'h7FC0_0000, 32'h4120_0000, 1'b0, 0, 0);
        run_op(32'h7F7F_FFFF, 32'h7F7F_FFFF, 1'b0, 0, 0);
        run_op(32'h7F80_0000, 32'h7F80_0000, 1'b1, 0, 0);
        run_op(32'hFF80_0000, 32'h3F80_0000, 1'b0, 0, 0);
        run_op(32'h8000_0000, 32'h0000_0000, 1'b1, 0, 0);
        run_op(32'h0080_0001, 32'h0080_0000, 1'b1, 0, 0);
        run_op(32'h4000_0000, 32'h0000_0000, 1'b0, 0, 0);
        run_op(32'h3F80_0000, 32'h3F80_0001, 1'b1, 0, 0);

        // Start held high (with changing operands) while busy.
        run_op(32'h3F80_0000, 32'h3E00_0000, 1'b0, 1, 0);

        // Reset during ALIGN aborts; start on the release cycle is accepted.
        @(negedge clk);
        a = 32'h3F80_0000; b = 32'h3E00_0000; op = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_ready", {31'd0, ready}, 32'd1);
        chk("abort_done", {31'd0, done}, 32'd0);
        chk("abort_result", result, 32'd0);
        repeat (6) begin
            @(posedge clk);
            #1;
            chk("abort_no_done", {31'd0, done}, 32'd0);
        end
        run_op(32'h4040_0000, 32'h3F80_0000, 1'b0, 0, 1);

        for (int i = 0; i < 250; i++) begin
            ra  = $urandom;
            rb  = $urandom;
            sel = $urandom_range(0, 9);
            if (sel < 6) begin
                etmp = ra[30:23] + 8'($urandom_range(0, 6)) - 8'd3;
                rb[30:23] = etmp;
            end else if (sel == 6) begin
                rb[30:0] = ra[30:0];
            end else if (sel == 7) begin
                rb[30:23] = 8'd0;
            end
            run_op(ra, rb, 1'($urandom_range(0, 1)), 0, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fpu_addsub_seq.md
FPU_ADDSUB_SEQ -- requirements
Module: fpu_addsub_seq

Interface
REQ-001 The block SHALL use a single clock; reset is synchronous and active-high.
REQ-002 Ports SHALL be:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- start  in  1  request; sampled only while ready=1
- a  in  32  IEEE-754 single operand A
- b  in  32  IEEE-754 single operand B
- op  in  1  0 = A+B, 1 = A-B
- ready  out  1  high only in IDLE
- done  out  1  one-cycle pulse; result and flags valid
- result  out  32  packed result, held until next accepted start
- nan  out  1  result is NaN
- zero  out  1  result is +/-0
- ovf  out  1  exponent overflow to infinity

Function
REQ-003 The FSM SHALL have states IDLE, UNPACK, ALIGN, ADD, NORM, DONE.
REQ-004 In IDLE with start=1, the block SHALL register a, b, op and go to UNPACK; start in any other state SHALL be ignored.
REQ-005 In UNPACK, the block SHALL set effective B sign = b[31] XOR op and treat exponent 0 as zero (flush denormals).
- It SHALL swap operands so the larger {E,M} is the big operand.
- It SHALL set d = min(Ebig-Esmall, 25).
- It SHALL form 24-bit mantissas with the hidden bit.
REQ-006 In UNPACK, special cases SHALL go straight to DONE:
- any NaN input -> 0x7FC00000, nan=1
- inf-inf (effective) -> 0x7FC00000, nan=1
- inf op finite -> that inf
- both zero -> +0 (or -0 if both effective signs are negative), zero=1
REQ-007 ALIGN SHALL shift the small mantissa right 1 bit per cycle and decrement d, exiting to ADD when d=0; it SHALL be skipped when d=0 on entry.
REQ-008 ADD SHALL take one cycle.
- Same effective signs: 25-bit sum.
- Different effective signs: big minus small.
- Sign SHALL be the big operand's sign; an exact zero difference SHALL give +0.
REQ-009 NORM SHALL evaluate the following once per cycle:
- carry out: shift right 1, E+1, then DONE
- mantissa = 0: zero result, then DONE
- bit23 = 0: shift left 1, E-1, stay in NORM
- otherwise: DONE
REQ-010 If E reaches 255 in NORM, the result SHALL be signed inf with ovf=1; if E would fall to 0, the result SHALL be signed zero with zero=1.
REQ-011 Rounding SHALL be truncation; bits shifted out are discarded.
REQ-012 DONE SHALL assert done for exactly one cycle, update result/nan/zero/ovf, then return to IDLE.
REQ-013 Latency from the start-sampling edge to done high SHALL be:
- special cases: 2 cycles
- otherwise: 4+d+n cycles, where n = left-shift count (0 for carry or exact zero)

Reset
REQ-014 With rst=1 at a clock edge, the block SHALL set state=IDLE, ready=1, done=0, result=0, nan=0, zero=0, ovf=0.
REQ-015 Reset mid-operation SHALL abort the operation with no done pulse; a start on the cycle rst deasserts SHALL be accepted normally.

Verification
REQ-016 The bench SHALL cover these directed scenarios:
- a=0x3F800000, b=0x3F800000, op=0 -> result 0x40000000, done at cycle 4, flags 0.
- a=0x3FC00000, b=0x3F800000, op=1 -> result 0x3F000000, done at cycle 5.
- a=0x3F800000, b=0x3E000000, op=0 (d=3) -> result 0x3F900000, done at cycle 7.
- a=0x3F800000, b=0x3F800000, op=1 -> result 0x00000000, zero=1, done at cycle 4.
- a=0x7FC00000, any b -> result 0x7FC00000, nan=1, done at cycle 2.
- a=b=0x7F7FFFFF, op=0 -> result 0x7F800000, ovf=1.
- rst pulsed during ALIGN -> no done, ready=1 next cycle.
- start held while busy -> ignored.
